// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: access-size
// encodings, FSM state type and a misalignment helper.
package mem_access_unit_pkg;

  localparam int DM_OP_BIT = 3;

  localparam logic [DM_OP_BIT-1:0] DM_W  = 3'd0;
  localparam logic [DM_OP_BIT-1:0] DM_H  = 3'd1;
  localparam logic [DM_OP_BIT-1:0] DM_HU = 3'd2;
  localparam logic [DM_OP_BIT-1:0] DM_B  = 3'd3;
  localparam logic [DM_OP_BIT-1:0] DM_BU = 3'd4;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_RESP = 2'd2
  } ma_state_t;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic is_misaligned(input logic [DM_OP_BIT-1:0] size,
                                         input logic [1:0] lo);
    case (size)
      DM_W:        return lo != 2'b00;
      DM_H, DM_HU: return lo[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_fmt.sv
// mem_lane_fmt: purely combinational byte-lane handling. The store side
// works on the incoming op (byte enables, lane replication, misalignment);
// the load side works on the latched op (lane extraction and extension).
module mem_lane_fmt
  import mem_access_unit_pkg::*;
(
  input  logic [DM_OP_BIT-1:0] op_size,
  input  logic [1:0]           op_addr_lo,
  input  logic [31:0]          op_wdata,
  output logic [3:0]           be,
  output logic [31:0]          wdata_rep,
  output logic                 misaligned,
  input  logic [DM_OP_BIT-1:0] ld_size,
  input  logic [1:0]           ld_addr_lo,
  input  logic [31:0]          rdata,
  output logic [31:0]          load_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte enables and store-data replication; misaligned halfwords align down via addr[1].
  always_comb begin
    be        = 4'b1111;
    wdata_rep = op_wdata;
    case (op_size)
      DM_B, DM_BU: begin
        be        = 4'b0001 << op_addr_lo;
        wdata_rep = {4{op_wdata[7:0]}};
      end
      DM_H, DM_HU: begin
        be        = op_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{op_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = op_wdata;
      end
    endcase
  end

  assign misaligned = is_misaligned(op_size, op_addr_lo);

  // Lane extraction followed by sign or zero extension.
  always_comb begin
    ld_byte  = rdata[7:0];
    ld_half  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_ext = rdata;
    case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    case (ld_size)
      DM_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      DM_BU:   load_ext = {24'd0, ld_byte};
      DM_H:    load_ext = {{16{ld_half[15]}}, ld_half};
      DM_HU:   load_ext = {16'd0, ld_half};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one load/store from the EX/MEM register into a
// req/ack RAM transaction, stalling upstream while the RAM is busy.
// Handshake: ram_req rises in REQ and is held, with address/enables/data
// stable, until the cycle ram_ack is seen high; ram_rdata is taken that
// same cycle. ram_ack in any other state is ignored.
// Build option MEM_MISALIGN_TRAP_EN: misaligned word/halfword ops are not
// issued and instead raise err; otherwise they are aligned down.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic                 op_we,
  input  logic [DM_OP_BIT-1:0] op_size,
  input  logic [31:0]          op_addr,
  input  logic [31:0]          op_wdata,
  input  logic                 flush,
  output logic                 ram_req,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [3:0]           ram_be,
  output logic [31:0]          ram_wdata,
  input  logic                 ram_ack,
  input  logic [31:0]          ram_rdata,
  output logic                 stall,
  output logic                 done,
  output logic [31:0]          load_data,
  output logic                 err,
  output ma_state_t            state_dbg
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  ma_state_t             state_q, state_d;
  logic [7:0]            timer_q;
  logic                  drop_q;
  logic                  trap_q;
  logic                  we_q;
  logic [DM_OP_BIT-1:0]  size_q;
  logic [1:0]            lo_q;
  logic [3:0]            fmt_be;
  logic [31:0]           fmt_wdata;
  logic [31:0]           fmt_load;
  logic                  fmt_mis;
  logic                  accept;
  logic                  trap_now;
  logic                  ack_take;
  logic                  timeout;

  mem_lane_fmt u_fmt (
    .op_size    (op_size),
    .op_addr_lo (op_addr[1:0]),
    .op_wdata   (op_wdata),
    .be         (fmt_be),
    .wdata_rep  (fmt_wdata),
    .misaligned (fmt_mis),
    .ld_size    (size_q),
    .ld_addr_lo (lo_q),
    .rdata      (ram_rdata),
    .load_ext   (fmt_load)
  );

  assign accept    = (state_q == MA_IDLE) && op_valid && !flush;
  assign state_dbg = state_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_now = accept && fmt_mis;
  logic unused_bits;
  assign unused_bits = ^{op_addr[31:ADDR_W+2]};
`else
  assign trap_now = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{op_addr[31:ADDR_W+2], fmt_mis};
`endif

  // Next-state and handshake outputs; a trapped op skips REQ entirely.
  always_comb begin
    state_d  = state_q;
    ram_req  = 1'b0;
    ram_we   = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    ack_take = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      MA_IDLE: begin
        stall = op_valid && !flush;
        if (accept) state_d = trap_now ? MA_RESP : MA_REQ;
      end
      MA_REQ: begin
        ram_req = 1'b1;
        ram_we  = we_q;
        stall   = 1'b1;
        if (ram_ack) begin
          ack_take = 1'b1;
          state_d  = MA_RESP;
        end else if (timer_q == TMO) begin
          err     = 1'b1;
          timeout = 1'b1;
          state_d = MA_IDLE;
        end
      end
      MA_RESP: begin
        done    = !drop_q && !trap_q && !flush;
        err     = trap_q;
        state_d = MA_IDLE;
      end
      default: state_d = MA_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MA_IDLE;
    else     state_q <= state_d;
  end

  // Request fields latched at acceptance so they stay stable while ram_req is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_be    <= '0;
      ram_wdata <= '0;
      we_q      <= 1'b0;
      size_q    <= DM_W;
      lo_q      <= 2'b00;
    end else if (accept) begin
      ram_addr  <= op_addr[ADDR_W+1:2];
      ram_be    <= fmt_be;
      ram_wdata <= fmt_wdata;
      we_q      <= op_we;
      size_q    <= op_size;
      lo_q      <= op_addr[1:0];
    end
  end

  // Timeout timer, drop flag (flush while the bus op is in flight) and trap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      drop_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else if (accept) begin
      timer_q <= '0;
      drop_q  <= 1'b0;
      trap_q  <= trap_now;
    end else if (state_q == MA_REQ) begin
      timer_q <= timer_q + 8'd1;
      if (flush) drop_q <= 1'b1;
    end
  end

  // Load result: formatted on ack, zero for stores, timeouts and traps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 load_data <= '0;
    else if (ack_take)       load_data <= we_q ? 32'd0 : fmt_load;
    else if (timeout)        load_data <= '0;
    else if (trap_now)       load_data <= '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized load/store
// traffic checked against a byte-arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 op_valid = 1'b0;
  logic                 op_we = 1'b0;
  logic [DM_OP_BIT-1:0] op_size = DM_W;
  logic [31:0]          op_addr = '0;
  logic [31:0]          op_wdata = '0;
  logic                 flush = 1'b0;
  logic                 ram_req;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [3:0]           ram_be;
  logic [31:0]          ram_wdata;
  logic                 ram_ack = 1'b0;
  logic [31:0]          ram_rdata = '0;
  logic                 stall;
  logic                 done;
  logic [31:0]          load_data;
  logic                 err;
  ma_state_t            state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_we(op_we),
    .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .stall(stall), .done(done), .load_data(load_data), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation hung");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] s);
    if (s == DM_B || s == DM_BU) return 1;
    if (s == DM_H || s == DM_HU) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return 4'(((1 << n) - 1) << lane_off(s, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] r;
    int n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a,
                                             input logic [31:0] r);
    logic [63:0] v, mask;
    int n = nbytes(s);
    mask = (64'd1 << (8*n)) - 64'd1;
    v = ({32'd0, r} >> (8*lane_off(s, a))) & mask;
    if ((s == DM_B || s == DM_H) && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bit model_mis(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return (n > 1) && ((a % n) != 0);
  endfunction

  // ---------------- driver ----------------
  // delay: REQ cycle index (0-based) on which ack is given; > TIMEOUT means never.
  // flush_at: REQ cycle index carrying flush (-1 none); flush_resp: flush during RESP.
  task automatic run_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int delay,
                        input int flush_at, input bit flush_resp);
    bit dropped, hit;
    logic [31:0] exp_ld;
    dropped = (flush_at >= 0 && flush_at <= delay && delay <= TIMEOUT) || flush_resp;
    exp_ld  = we ? 32'd0 : model_load(sz, a, rd);
    hit     = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; op_we = we; op_size = sz; op_addr = a; op_wdata = d;
    #1;
    check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (model_mis(sz, a)) begin
      @(negedge clk);
      check("trap_req", 32'(ram_req), 32'd0);
      check("trap_err", 32'(err), 32'd1);
      check("trap_done", 32'(done), 32'd0);
      check("trap_ld", load_data, 32'd0);
      @(posedge clk); #1;
      return;
    end
`endif
    for (int k = 0; k <= TIMEOUT; k++) begin
      ram_ack   = (k == delay);
      ram_rdata = (k == delay) ? rd : $urandom;
      flush     = (k == flush_at);
      @(negedge clk);
      check("req", 32'(ram_req), 32'd1);
      check("we", 32'(ram_we), 32'(we));
      check("addr", 32'(ram_addr), 32'(a[ADDR_W+1:2]));
      check("be", 32'(ram_be), 32'(model_be(sz, a)));
      check("stall_req", 32'(stall), 32'd1);
      if (we) check("wdata", ram_wdata, model_wdata(sz, d));
      if (k == TIMEOUT && k != delay) begin
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_done", 32'(done), 32'd0);
      end else begin
        check("err_req", 32'(err), 32'd0);
      end
      hit = (k == delay);
      @(posedge clk); #1;
      ram_ack = 1'b0; flush = 1'b0;
      if (hit) break;
    end
    if (hit) begin
      flush = flush_resp;
      if (!dropped) exp_q.push_back(exp_ld);
      @(negedge clk);
      check("done", 32'(done), dropped ? 32'd0 : 32'd1);
      check("stall_resp", 32'(stall), 32'd0);
      check("req_resp", 32'(ram_req), 32'd0);
      check("err_resp", 32'(err), 32'd0);
      if (!dropped && exp_q.size() > 0) check("load_data", load_data, exp_q.pop_front());
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("done_bubble", 32'(done), 32'd0);
    end else begin
      @(negedge clk);
      check("tmo_req_low", 32'(ram_req), 32'd0);
      check("tmo_stall_low", 32'(stall), 32'd0);
      check("tmo_err_low", 32'(err), 32'd0);
      check("tmo_done_low", 32'(done), 32'd0);
      check("tmo_ld", load_data, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] sz;
    int delay, fat;
    bit fr;
    #1;
    check("rst_req", 32'(ram_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_be", 32'(ram_be), 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_ld", load_data, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(MA_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op(1'b1, DM_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, -1, 1'b0);
    run_op(1'b0, DM_B,  32'h0000_0013, 32'h0, 32'h80FF_0000, 0, -1, 1'b0);
    run_op(1'b0, DM_BU, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1, -1, 1'b0);
    run_op(1'b0, DM_H,  32'h0000_0022, 32'h0, 32'h8001_1234, 0, -1, 1'b0);
    run_op(1'b0, DM_HU, 32'h0000_0022, 32'h0, 32'h8001_1234, 2, -1, 1'b0);
    run_op(1'b1, DM_B,  32'h0000_0031, 32'h0000_00A5, 32'h0, 0, -1, 1'b0);
    run_op(1'b1, DM_H,  32'h0000_0036, 32'h0000_C3D2, 32'h0, 1, -1, 1'b0);
    run_op(1'b0, DM_W,  32'h0000_0040, 32'h0, 32'h1234_5678, 99, -1, 1'b0);
    run_op(1'b0, DM_W,  32'h0000_0044, 32'h0, 32'h1111_2222, 3, 1, 1'b0);
    run_op(1'b0, DM_W,  32'h0000_0048, 32'h0, 32'h3333_4444, 0, -1, 1'b1);
    run_op(1'b0, DM_W,  32'h0000_0002, 32'h0, 32'hCAFE_F00D, 0, -1, 1'b0);

    // flush in IDLE: op not accepted, no stall
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_size = DM_W; op_addr = 32'h50; flush = 1'b1;
    #1;
    check("flush_idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_req", 32'(ram_req), 32'd0);

    // ram_ack while idle is ignored
    ram_ack = 1'b1;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_done", 32'(done), 32'd0);
    check("stray_ack_req", 32'(ram_req), 32'd0);

    // reset in the middle of a transaction
    op_valid = 1'b1; op_we = 1'b1; op_size = DM_W; op_addr = 32'h60; op_wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(ram_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(ram_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sz    = 3'($urandom_range(0, 4));
      delay = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 4));
      fat   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      fr    = ($urandom_range(0, 7) == 0);
      run_op(1'($urandom), sz, {20'd0, 12'($urandom)}, $urandom, $urandom, delay, fat, fr);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
